pattern_seq: RTL

PATTERN_SEQ -- requirements
Module: pattern_seq

---
 rtl/pattern_seq.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pattern_seq.sv
// pattern_seq: triggered pattern sequencer.
//
// On an accepted trigger the block plays steps 0..L-1 of a small pattern
// memory on O. Here L = min(len, DEPTH), and len is sampled when the trigger
// is accepted. Step 0 appears in the trigger cycle itself, with zero latency.
// Triggers are ignored while a sequence is running. The pattern memory can be
// written at any time and reloads INIT on reset.
//
// Optional feature: define PATTERN_SEQ_LOOP_EN to add the `loop` input.
// With loop high at the final step, the sequence wraps to step 0 instead of
// ending.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous, active-low reset
//   I        in   trigger
//   len      in   sequence length in steps (clamped to DEPTH)
//   loop     in   repeat the sequence (only with PATTERN_SEQ_LOOP_EN)
//   wr_en    in   pattern memory write strobe
//   wr_addr  in   step index to write
//   wr_data  in   step value to write
//   O        out  current step value (0 when idle)
//   busy     out  registered, high while in RUN
//   done     out  combinational, high while the final step is presented
//
// state | meaning
// IDLE  | waiting for a trigger; step 0 is driven combinationally on trigger
// RUN   | presenting steps 1..len_q-1, one per cycle

module pattern_seq #(
    parameter int                     WIDTH = 1,
    parameter int                     DEPTH = 8,
    parameter logic [DEPTH*WIDTH-1:0] INIT  = 8'h31,
    localparam int                    LW    = $clog2(DEPTH + 1),
    localparam int                    AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             I,
    input  logic [LW-1:0]    len,
`ifdef PATTERN_SEQ_LOOP_EN
    input  logic             loop,
`endif
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] O,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [AW:0]   DEPTH_A = (AW + 1)'(DEPTH);

    state_t           state, state_nx;
    logic [AW-1:0]    step, step_nx;
    logic [LW-1:0]    len_q, len_nx;
    logic             busy_q;
    logic [WIDTH-1:0] mem [DEPTH];

    logic [LW-1:0]    l_eff;
    logic [LW-1:0]    last_step;
    logic             at_last;
    logic             addr_ok;
    logic             loop_c;
    logic [WIDTH-1:0] o_val;
    logic             done_c;

`ifdef PATTERN_SEQ_LOOP_EN
    assign loop_c = loop;
`else
    assign loop_c = 1'b0;
`endif

    assign l_eff     = (len > DEPTH_L) ? DEPTH_L : len;
    assign last_step = len_q - LW'(1);
    assign at_last   = (LW'(step) == last_step);
    assign addr_ok   = ({1'b0, wr_addr} < DEPTH_A);

    // The memory is read combinationally before the write edge. A write to
    // the step being shown therefore leaves this cycle's O at the old value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= INIT[i*WIDTH +: WIDTH];
            end
        end else if (wr_en && addr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            step   <= '0;
            len_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nx;
            step   <= step_nx;
            len_q  <= len_nx;
            busy_q <= (state_nx == RUN);
        end
    end

    always_comb begin
        state_nx = state;
        step_nx  = step;
        len_nx   = len_q;
        o_val    = '0;
        done_c   = 1'b0;
        case (state)
            IDLE: begin
                if (I && (l_eff != '0)) begin
                    o_val = mem[0];
                    if (l_eff == LW'(1)) begin
                        done_c = 1'b1;
                    end else begin
                        len_nx   = l_eff;
                        step_nx  = AW'(1);
                        state_nx = RUN;
                    end
                end
            end
            RUN: begin
                o_val = mem[step];
                if (at_last) begin
                    done_c  = 1'b1;
                    step_nx = '0;
                    if (!loop_c) begin
                        state_nx = IDLE;
                    end
                end else begin
                    step_nx = step + AW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                step_nx  = '0;
            end
        endcase
    end

    // State is already forced to IDLE while reset is low. The gating below
    // also suppresses the zero-latency trigger path during reset.
    assign O    = reset ? o_val : '0;
    assign done = reset & done_c;
    assign busy = busy_q;

endmodule
